// File: rtl/mvm_accum_pkg.sv
// Shared widths, shift constants and FSM encoding for the mvm_accum stage.
package mvm_accum_pkg;

    localparam int unsigned DEF_VP   = 3;
    localparam int unsigned DEF_EP   = 3;
    localparam int unsigned DEF_WI_X = 4;
    localparam int unsigned DEF_WF_X = 12;
    localparam int unsigned DEF_WI_W = 4;
    localparam int unsigned DEF_WF_W = 12;
    localparam int unsigned DEF_WI_O = 4;
    localparam int unsigned DEF_WF_O = 12;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Full-precision product width: integer and fraction bits of both operands.
    function automatic int unsigned prod_w(input int unsigned wi_x, input int unsigned wf_x,
                                           input int unsigned wi_w, input int unsigned wf_w);
        return wi_x + wf_x + wi_w + wf_w;
    endfunction

    // Guard bits so an EP-term sum of products can never wrap.
    function automatic int unsigned guard_w(input int unsigned ep);
        return $clog2(ep);
    endfunction

    // Accumulator width: product plus guard bits.
    function automatic int unsigned acc_w(input int unsigned wi_x, input int unsigned wf_x,
                                          input int unsigned wi_w, input int unsigned wf_w,
                                          input int unsigned ep);
        return prod_w(wi_x, wf_x, wi_w, wf_w) + guard_w(ep);
    endfunction

    // Fraction bits dropped when narrowing the accumulator to the output format.
    function automatic int unsigned rnd_shift(input int unsigned wf_x, input int unsigned wf_w,
                                              input int unsigned wf_o);
        return wf_x + wf_w - wf_o;
    endfunction

endpackage

// File: rtl/mvm_lane.sv
// One output lane: product register, accumulator and round/saturate result register.
module mvm_lane
    import mvm_accum_pkg::*;
#(
    parameter int unsigned EP   = DEF_EP,
    parameter int unsigned WI_X = DEF_WI_X,
    parameter int unsigned WF_X = DEF_WF_X,
    parameter int unsigned WI_W = DEF_WI_W,
    parameter int unsigned WF_W = DEF_WF_W,
    parameter int unsigned WI_O = DEF_WI_O,
    parameter int unsigned WF_O = DEF_WF_O
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            load,
    input  logic                            add,
    input  logic                            round,
    input  logic signed [WI_X+WF_X-1:0]     x,
    input  logic signed [WI_W+WF_W-1:0]     w,
    output logic        [WI_O+WF_O-1:0]     data,
    output logic                            ovf
);

    localparam int unsigned PW   = prod_w(WI_X, WF_X, WI_W, WF_W);
    localparam int unsigned AW   = acc_w(WI_X, WF_X, WI_W, WF_W, EP);
    localparam int unsigned RW   = AW + 1;
    localparam int unsigned OW   = WI_O + WF_O;
    localparam int unsigned SH   = rnd_shift(WF_X, WF_W, WF_O);
    localparam int unsigned RSH  = (SH == 0) ? 0 : SH - 1;

    localparam logic signed [RW-1:0] RND     = (SH == 0) ? '0 : (RW'(1) <<< RSH);
    localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [PW-1:0] p;
    logic signed [AW-1:0] acc;
    logic signed [RW-1:0] rnd_sum;
    logic signed [RW-1:0] shr;
    logic        [OW-1:0] sat_c;
    logic                 ovf_c;

    // Round half toward +inf, then clip to the output range.
    always_comb begin
        rnd_sum = RW'(acc) + RND;
        shr     = rnd_sum >>> SH;
        sat_c   = OW'(shr);
        ovf_c   = 1'b0;
        if (shr > SAT_MAX) begin
            sat_c = OW'(SAT_MAX);
            ovf_c = 1'b1;
        end else if (shr < SAT_MIN) begin
            sat_c = OW'(SAT_MIN);
            ovf_c = 1'b1;
        end
    end

    // Product stage, accumulate, and result capture; clr wipes partial work only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p    <= '0;
            acc  <= '0;
            data <= '0;
            ovf  <= 1'b0;
        end else if (clr) begin
            p    <= '0;
            acc  <= '0;
        end else begin
            if (load) begin
                p <= PW'(x) * PW'(w);
            end
            if (round) begin
                acc  <= '0;
                data <= sat_c;
                ovf  <= ovf_c;
            end else if (add) begin
                acc <= acc + AW'(p);
            end
        end
    end

endmodule

// File: rtl/mvm_accum.sv
// Streaming VP-lane matrix-vector multiply-accumulate with round/saturate output.
module mvm_accum
    import mvm_accum_pkg::*;
#(
    parameter int unsigned VP   = DEF_VP,
    parameter int unsigned EP   = DEF_EP,
    parameter int unsigned WI_X = DEF_WI_X,
    parameter int unsigned WF_X = DEF_WF_X,
    parameter int unsigned WI_W = DEF_WI_W,
    parameter int unsigned WF_W = DEF_WF_W,
    parameter int unsigned WI_O = DEF_WI_O,
    parameter int unsigned WF_O = DEF_WF_O
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WI_X+WF_X-1:0]          s_x,
    input  logic [VP*(WI_W+WF_W)-1:0]     s_w,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [VP*(WI_O+WF_O)-1:0]     m_data,
    output logic [VP-1:0]                 m_ovf
);

    localparam int unsigned WW = WI_W + WF_W;
    localparam int unsigned OW = WI_O + WF_O;
    localparam int unsigned CW = (EP > 1) ? $clog2(EP) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          p_valid;
    logic          s_hs_c;

    assign s_hs_c = s_valid && s_ready && (state == ACC);

    // Beat counter, handshakes and phase sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACC;
            cnt     <= '0;
            p_valid <= 1'b0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
        end else if (clr) begin
            state   <= ACC;
            cnt     <= '0;
            p_valid <= 1'b0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    s_ready <= 1'b1;
                    p_valid <= s_hs_c;
                    if (s_hs_c) begin
                        if (cnt == CW'(EP - 1)) begin
                            cnt     <= '0;
                            state   <= DRAIN;
                            s_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    p_valid <= 1'b0;
                    state   <= ROUND;
                end
                ROUND: begin
                    m_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    // One lane per output row; lane 0 occupies the MSBs of the packed buses.
    for (genvar i = 0; i < int'(VP); i++) begin : g_lane
        mvm_lane #(
            .EP   (EP),
            .WI_X (WI_X),
            .WF_X (WF_X),
            .WI_W (WI_W),
            .WF_W (WF_W),
            .WI_O (WI_O),
            .WF_O (WF_O)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .load  (s_hs_c),
            .add   (p_valid),
            .round (state == ROUND),
            .x     (s_x),
            .w     (s_w[(VP-1-i)*WW +: WW]),
            .data  (m_data[(VP-1-i)*OW +: OW]),
            .ovf   (m_ovf[i])
        );
    end

endmodule

// File: tb/tb_mvm_accum.sv
// Scoreboard bench for mvm_accum at VP=3, EP=3, Q4.12 in/out.
module tb_mvm_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_x;
    logic [47:0] s_w;
    logic        m_valid;
    logic        m_ready;
    logic [47:0] m_data;
    logic [2:0]  m_ovf;

    typedef struct {
        logic [47:0] d;
        logic [2:0]  o;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] vx [3];
    logic [15:0] vw [3][3];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mvm_accum dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_x     (s_x),
        .s_w     (s_w),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_ovf   (m_ovf)
    );

    // Reference: exact integer dot product, +2^11, >>>12, clip to 16 bits.
    function automatic exp_t model();
        exp_t   e;
        longint acc;
        longint r;
        e.d = '0;
        e.o = '0;
        for (int l = 0; l < 3; l++) begin
            acc = 0;
            for (int b = 0; b < 3; b++)
                acc += longint'($signed(vx[b])) * longint'($signed(vw[b][l]));
            r = (acc + 64'sd2048) >>> 12;
            if (r > 32767) begin
                r = 32767;
                e.o[l] = 1'b1;
            end else if (r < -32768) begin
                r = -32768;
                e.o[l] = 1'b1;
            end
            e.d[(2-l)*16 +: 16] = 16'(r);
        end
        return e;
    endfunction

    task automatic set_vec(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                           input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        vx[0] = x0; vx[1] = x1; vx[2] = x2;
        for (int b = 0; b < 3; b++) begin
            vw[b][0] = w0; vw[b][1] = w1; vw[b][2] = w2;
        end
    endtask

    task automatic drive_beat(input int b);
        bit hs = 1'b0;
        s_valid = 1'b1;
        s_x     = vx[b];
        s_w     = {vw[b][0], vw[b][1], vw[b][2]};
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = s_ready;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!hs) begin
            total++; bad++;
            $display("FAIL beat_accept beat=%0d: s_ready never seen high, required 1", b);
        end
    endtask

    task automatic send_vec(input int gap, input bit push);
        if (push) sbq.push_back(model());
        for (int b = 0; b < 3; b++) begin
            drive_beat(b);
            if (b < 2) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_valid(output bit ok);
        for (int i = 0; i < 30 && !m_valid; i++) begin
            @(posedge clk); #1;
        end
        ok = m_valid;
    endtask

    task automatic get_result(input int hold, input string name);
        bit          ok;
        exp_t        e;
        logic [47:0] d0;
        int          unstable = 0;
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout: m_valid=%b, required 1", name, m_valid);
            return;
        end
        d0 = m_data;
        repeat (hold) begin
            if (m_data !== d0 || s_ready !== 1'b0 || m_valid !== 1'b1) unstable++;
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            total++;
            if (unstable !== 0) begin
                bad++;
                $display("FAIL %s_hold: %0d unstable cycles, required 0", name, unstable);
            end
        end
        if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_sb: result with empty scoreboard", name);
        end else begin
            e = sbq.pop_front();
            total++;
            if (m_data !== e.d) begin
                bad++;
                $display("FAIL %s_data: got %h, required %h", name, m_data, e.d);
            end
            total++;
            if (m_ovf !== e.o) begin
                bad++;
                $display("FAIL %s_ovf: got %b, required %b", name, m_ovf, e.o);
            end
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_release: m_valid=%b s_ready=%b, required 0 1", name, m_valid, s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_x = '0; s_w = '0;
        #12;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== '0 || m_ovf !== '0) begin
            bad++;
            $display("FAIL reset_state: v=%b r=%b d=%h o=%b, required 0 0 0 0",
                     m_valid, s_ready, m_data, m_ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: s_ready=%b, required 1", s_ready);
        end
    endtask

    task automatic test_basic();
        logic [2:0] lat;
        set_vec(16'h1000, 16'h2000, 16'h0800, 16'h1000, 16'hF000, 16'h0000);
        send_vec(0, 1'b1);
        lat[0] = m_valid;
        @(posedge clk); #1; lat[1] = m_valid;
        @(posedge clk); #1; lat[2] = m_valid;
        total++;
        if (lat !== 3'b100) begin
            bad++;
            $display("FAIL basic_latency: m_valid after edges 1..3 = %b%b%b, required 001",
                     lat[0], lat[1], lat[2]);
        end
        total++;
        if (m_data !== 48'h3800_C800_0000) begin
            bad++;
            $display("FAIL basic_const: got %h, required 3800c8000000", m_data);
        end
        get_result(0, "basic");
    endtask

    task automatic test_saturation();
        set_vec(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
        send_vec(0, 1'b1);
        get_result(0, "sat_pos");
        set_vec(16'h7000, 16'h7000, 16'h7000, 16'h9000, 16'h9000, 16'h9000);
        send_vec(0, 1'b1);
        get_result(0, "sat_neg");
    endtask

    task automatic test_rounding();
        set_vec(16'h0001, 16'h0000, 16'h0000, 16'h0800, 16'h0800, 16'h0800);
        send_vec(0, 1'b1);
        get_result(0, "rnd_pos_half");
        set_vec(16'hFFFF, 16'h0000, 16'h0000, 16'h0800, 16'h0800, 16'h0800);
        send_vec(0, 1'b1);
        get_result(0, "rnd_neg_half");
        set_vec(16'h0003, 16'h0000, 16'h0000, 16'h0800, 16'h0800, 16'h0800);
        send_vec(0, 1'b1);
        get_result(0, "rnd_three_half");
    endtask

    task automatic test_back_to_back();
        set_vec(16'h1000, 16'h2000, 16'h0800, 16'h1000, 16'hF000, 16'h0000);
        send_vec(2, 1'b1);
        get_result(10, "gap_hold");
        set_vec(16'h2000, 16'h0000, 16'h0000, 16'h1000, 16'h1000, 16'h1000);
        send_vec(0, 1'b1);
        get_result(0, "fresh_acc");
    endtask

    task automatic test_abort();
        bit ok;
        set_vec(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
        drive_beat(0);
        drive_beat(1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: s_ready=%b m_valid=%b, required 1 0", s_ready, m_valid);
        end
        set_vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000);
        send_vec(0, 1'b1);
        get_result(0, "abort_clean");
        send_vec(0, 1'b0);
        wait_valid(ok);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        total++;
        if (!ok || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_out: seen=%b m_valid=%b s_ready=%b, required 1 0 1",
                     ok, m_valid, s_ready);
        end
    endtask

    task automatic test_reset_out();
        bit ok;
        set_vec(16'h1000, 16'h2000, 16'h0800, 16'h1000, 16'hF000, 16'h0000);
        send_vec(0, 1'b0);
        wait_valid(ok);
        #2 rst = 1'b1;
        #1;
        total++;
        if (!ok || m_valid !== 1'b0 || m_data !== '0 || m_ovf !== '0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: seen=%b v=%b d=%h o=%b r=%b, required 1 0 0 0 0",
                     ok, m_valid, m_data, m_ovf, s_ready);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_rearm: s_ready=%b, required 1", s_ready);
        end
        set_vec(16'hE000, 16'h1000, 16'h0400, 16'h1000, 16'h2000, 16'hC000);
        send_vec(0, 1'b1);
        get_result(0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_abort();
        test_reset_out();
        total++;
        if (sbq.size() !== 0) begin
            bad++;
            $display("FAIL sb_drain: %0d results outstanding, required 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
